// File: rtl/gt_rx_deframer_if.sv
// Word-stream bundle around gt_rx_deframer: decoded GT receive bytes in, framed payload out.
// master = deframer side, slave = GT/user-logic side.
interface gt_rx_deframer_if;
    logic [15:0] rx_data_i;
    logic [1:0]  rx_charisk_i;
    logic [1:0]  rx_codeerr_i;
    logic [15:0] m_data_o;
    logic        m_valid_o;
    logic        m_sof_o;
    logic        m_eof_o;
    logic        m_err_o;

    modport master (
        input  rx_data_i, rx_charisk_i, rx_codeerr_i,
        output m_data_o, m_valid_o, m_sof_o, m_eof_o, m_err_o
    );
    modport slave (
        output rx_data_i, rx_charisk_i, rx_codeerr_i,
        input  m_data_o, m_valid_o, m_sof_o, m_eof_o, m_err_o
    );
endinterface

// File: rtl/gt_rx_deframer.sv
// GTX receive deframer: K28.5 byte alignment, lock tracking, idle stripping, SOF/EOF framing.
// Define DEFRAMER_STATS_EN to build the frame/error counters; otherwise they read 0.
module gt_rx_deframer #(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             rx_resetdone_i,
    gt_rx_deframer_if.master bus,
    output logic             link_up_o,
    output logic             align_o,
    output logic [15:0]      frame_cnt_o,
    output logic [15:0]      err_cnt_o
);
    localparam logic [7:0] LOCK_C = 8'(LOCK_CNT);
    localparam logic [7:0] LOSS_C = 8'(LOSS_CNT);

    typedef enum logic [1:0] {CLS_DATA, CLS_IDLE, CLS_SOF, CLS_EOF} cls_e;
    typedef enum logic [1:0] {ST_HUNT, ST_VERIFY, ST_LOCKED} state_e;

    typedef struct packed {
        logic [15:0] word;
        cls_e        cls;
        logic        err;
        logic        comma;
    } cword_t;

    // Control words must carry their fixed hi byte; anything else with a K flag is a code error.
    function automatic cword_t classify(input logic [15:0] w, input logic [1:0] k,
                                        input logic [1:0] ce);
        cword_t c;
        c.word  = w;
        c.cls   = CLS_DATA;
        c.err   = (|ce) | k[1];
        c.comma = k[0] && (w[7:0] == 8'hBC);
        if (k[0]) begin
            case (w[7:0])
                8'hBC: begin
                    c.cls = CLS_IDLE;
                    if (w[15:8] != 8'h50) c.err = 1'b1;
                end
                8'hFB: begin
                    c.cls = CLS_SOF;
                    if (w[15:8] != 8'h00) c.err = 1'b1;
                end
                8'hFD: begin
                    c.cls = CLS_EOF;
                    if (w[15:8] != 8'h00) c.err = 1'b1;
                end
                default: c.err = 1'b1;
            endcase
        end
        return c;
    endfunction

    // Input register plus the byte-1 half of the previous word for offset-1 alignment.
    logic [15:0] in_data_q;
    logic [1:0]  in_k_q, in_ce_q;
    logic [7:0]  prev_hi_q;
    logic        prev_khi_q, prev_cehi_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            in_data_q   <= '0;
            in_k_q      <= '0;
            in_ce_q     <= '0;
            prev_hi_q   <= '0;
            prev_khi_q  <= 1'b0;
            prev_cehi_q <= 1'b0;
        end else begin
            prev_hi_q   <= in_data_q[15:8];
            prev_khi_q  <= in_k_q[1];
            prev_cehi_q <= in_ce_q[1];
            in_data_q   <= bus.rx_data_i;
            in_k_q      <= bus.rx_charisk_i;
            in_ce_q     <= bus.rx_codeerr_i;
        end
    end

    // Both offsets are classified every cycle so an alignment change never mis-decodes a word.
    cword_t c0_q, c1_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            c0_q <= '0;
            c1_q <= '0;
        end else begin
            c0_q <= classify(in_data_q, in_k_q, in_ce_q);
            c1_q <= classify({in_data_q[7:0], prev_hi_q}, {in_k_q[0], prev_khi_q},
                             {in_ce_q[0], prev_cehi_q});
        end
    end

    state_e      state_q, state_n;
    logic [7:0]  cnt_q, cnt_n;
    logic        align_q, align_n;
    logic [15:0] sel_word;
    cls_e        sel_cls;
    logic        sel_err, oth_comma, bad;
    logic        is_idle, is_sof, is_eof, is_data;

    always_comb begin
        sel_word  = align_q ? c1_q.word  : c0_q.word;
        sel_cls   = align_q ? c1_q.cls   : c0_q.cls;
        sel_err   = align_q ? c1_q.err   : c0_q.err;
        oth_comma = align_q ? c0_q.comma : c1_q.comma;
        bad       = sel_err | oth_comma;
        is_idle   = !bad && (sel_cls == CLS_IDLE);
        is_sof    = !bad && (sel_cls == CLS_SOF);
        is_eof    = !bad && (sel_cls == CLS_EOF);
        is_data   = !bad && (sel_cls == CLS_DATA);
    end

    // cnt counts commas in VERIFY and consecutive errored words in LOCKED.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        align_n = align_q;
        case (state_q)
            ST_HUNT: begin
                if (c0_q.comma || c1_q.comma) begin
                    align_n = !c0_q.comma;
                    cnt_n   = 8'd1;
                    state_n = ST_VERIFY;
                end
            end
            ST_VERIFY: begin
                if (bad) begin
                    state_n = ST_HUNT;
                end else if (is_idle) begin
                    cnt_n = cnt_q + 8'd1;
                    if (cnt_n == LOCK_C) begin
                        state_n = ST_LOCKED;
                        cnt_n   = 8'd0;
                    end
                end
            end
            ST_LOCKED: begin
                if (bad) begin
                    cnt_n = cnt_q + 8'd1;
                    if (cnt_n == LOSS_C) state_n = ST_HUNT;
                end else if (is_idle) begin
                    cnt_n = 8'd0;
                end
            end
            default: state_n = ST_HUNT;
        endcase
        if (!rx_resetdone_i) state_n = ST_HUNT;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_HUNT;
            cnt_q   <= '0;
            align_q <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            align_q <= align_n;
        end
    end

    // One-deep hold lets the following EOF/abort tag the last data word of a frame.
    logic        in_frame_q, in_frame_n;
    logic        hold_vld_q, hold_vld_n;
    logic        hold_sof_q, hold_sof_n;
    logic [15:0] hold_word_q;
    logic        hold_load, abort, frame_done, data_fwd, emit, leave;

    always_comb begin
        in_frame_n = in_frame_q;
        hold_vld_n = hold_vld_q;
        hold_sof_n = hold_sof_q;
        hold_load  = 1'b0;
        abort      = 1'b0;
        frame_done = 1'b0;
        data_fwd   = 1'b0;
        leave      = (state_q == ST_LOCKED) && (state_n != ST_LOCKED);
        if (state_q == ST_LOCKED) begin
            if (leave || bad || is_idle) begin
                abort      = in_frame_q;
                in_frame_n = 1'b0;
                hold_vld_n = 1'b0;
            end else if (is_sof) begin
                abort      = in_frame_q;
                in_frame_n = 1'b1;
                hold_vld_n = 1'b0;
            end else if (is_eof) begin
                frame_done = in_frame_q && hold_vld_q;
                in_frame_n = 1'b0;
                hold_vld_n = 1'b0;
            end else if (is_data && in_frame_q) begin
                data_fwd   = 1'b1;
                hold_load  = 1'b1;
                hold_vld_n = 1'b1;
                hold_sof_n = !hold_vld_q;
            end
        end else begin
            in_frame_n = 1'b0;
            hold_vld_n = 1'b0;
        end
        emit = hold_vld_q && (abort || frame_done || data_fwd);
    end

    logic [15:0] m_data_q;
    logic        m_valid_q, m_sof_q, m_eof_q, m_err_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            in_frame_q  <= 1'b0;
            hold_vld_q  <= 1'b0;
            hold_sof_q  <= 1'b0;
            hold_word_q <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_sof_q     <= 1'b0;
            m_eof_q     <= 1'b0;
            m_err_q     <= 1'b0;
        end else begin
            in_frame_q <= in_frame_n;
            hold_vld_q <= hold_vld_n;
            hold_sof_q <= hold_sof_n;
            if (hold_load) hold_word_q <= sel_word;
            if (emit) m_data_q <= hold_word_q;
            m_valid_q <= emit;
            m_sof_q   <= emit & hold_sof_q;
            m_eof_q   <= emit & (abort | frame_done);
            m_err_q   <= emit & abort;
        end
    end

    assign bus.m_data_o  = m_data_q;
    assign bus.m_valid_o = m_valid_q;
    assign bus.m_sof_o   = m_sof_q;
    assign bus.m_eof_o   = m_eof_q;
    assign bus.m_err_o   = m_err_q;
    assign link_up_o     = (state_q == ST_LOCKED);
    assign align_o       = align_q;

`ifdef DEFRAMER_STATS_EN
    // One error event per word: an errored word and the abort it causes count once.
    logic        err_inc;
    logic [15:0] frame_cnt_q, err_cnt_q;

    assign err_inc = abort | ((state_q != ST_HUNT) & bad);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (frame_done) frame_cnt_q <= frame_cnt_q + 16'd1;
            if (err_inc && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign frame_cnt_o = frame_cnt_q;
    assign err_cnt_o   = err_cnt_q;
`else
    assign frame_cnt_o = '0;
    assign err_cnt_o   = '0;
`endif
endmodule

// File: tb/tb_gt_rx_deframer.sv
// Directed bench for gt_rx_deframer: lock at both offsets, framing, abort, loss and GT reset.
module tb_gt_rx_deframer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdone = 1'b0;
    logic        link_up, align;
    logic [15:0] fcnt, ecnt;

    gt_rx_deframer_if bus();

    gt_rx_deframer #(.LOCK_CNT(4), .LOSS_CNT(8)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .rx_resetdone_i (rdone),
        .bus            (bus),
        .link_up_o      (link_up),
        .align_o        (align),
        .frame_cnt_o    (fcnt),
        .err_cnt_o      (ecnt)
    );

    always #5 clk = ~clk;

`ifdef DEFRAMER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam logic [15:0] W_IDLE = 16'h50BC;
    localparam logic [15:0] W_SOF  = 16'h00FB;
    localparam logic [15:0] W_EOF  = 16'h00FD;

    int   vectors = 0;
    int   fails   = 0;
    bit   shift   = 1'b0;
    logic [7:0] pend_hi = 8'h50;
    logic       pend_k  = 1'b0;
    logic [1:0] ce      = 2'b00;
    logic [18:0] q[$];
    logic [18:0] e;

    // Emitted words as {sof, eof, err, data}.
    always @(negedge clk)
        if (bus.m_valid_o) q.push_back({bus.m_sof_o, bus.m_eof_o, bus.m_err_o, bus.m_data_o});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one aligned word; in shift mode the stream is delayed by one byte.
    task automatic put(input logic [15:0] w, input logic [1:0] k);
        if (shift) begin
            bus.rx_data_i    = {w[7:0], pend_hi};
            bus.rx_charisk_i = {k[0], pend_k};
            pend_hi          = w[15:8];
            pend_k           = k[1];
        end else begin
            bus.rx_data_i    = w;
            bus.rx_charisk_i = k;
        end
        bus.rx_codeerr_i = ce;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) put(W_IDLE, 2'b01);
    endtask

    task automatic pop(input string tag, input logic [18:0] exp);
        if (q.size() == 0) begin
            chk({tag, "_present"}, 32'd0, 32'd1);
        end else begin
            e = q.pop_front();
            chk(tag, {13'd0, e}, {13'd0, exp});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bus.rx_data_i = '0; bus.rx_charisk_i = '0; bus.rx_codeerr_i = '0;
        rdone = 1'b1;
        step(); step();
        chk("rst_link", {31'd0, link_up}, 32'd0);
        chk("rst_align", {31'd0, align}, 32'd0);
        chk("rst_valid", {31'd0, bus.m_valid_o}, 32'd0);
        chk("rst_outs", {13'd0, bus.m_sof_o, bus.m_eof_o, bus.m_err_o, bus.m_data_o}, 32'd0);
        chk("rst_cnts", {fcnt, ecnt}, 32'd0);
        rst_n = 1'b1;

        // Offset 0 lock: 4th comma processed two edges after it is driven.
        idle(5);
        chk("lock0_early", {31'd0, link_up}, 32'd0);
        idle(1);
        chk("lock0_up", {31'd0, link_up}, 32'd1);
        chk("lock0_align", {31'd0, align}, 32'd0);

        // Exact latency: word captured at edge N appears at N+3.
        put(W_SOF, 2'b01);
        put(16'h1111, 2'b00);
        put(16'h2222, 2'b00);
        put(W_EOF, 2'b01);
        put(W_IDLE, 2'b01);
        chk("lat_w0", {12'd0, bus.m_valid_o, bus.m_sof_o, bus.m_eof_o, bus.m_err_o, bus.m_data_o},
            {12'd0, 4'b1100, 16'h1111});
        put(W_IDLE, 2'b01);
        chk("lat_w1", {12'd0, bus.m_valid_o, bus.m_sof_o, bus.m_eof_o, bus.m_err_o, bus.m_data_o},
            {12'd0, 4'b1010, 16'h2222});
        chk("lat_fcnt", {16'd0, fcnt}, STATS ? 32'd1 : 32'd0);
        put(W_IDLE, 2'b01);
        chk("lat_gap", {31'd0, bus.m_valid_o}, 32'd0);
        q.delete();

        // Single-word frame, then an empty frame.
        put(W_SOF, 2'b01); put(16'hABCD, 2'b00); put(W_EOF, 2'b01); idle(4);
        pop("single", {3'b110, 16'hABCD});
        chk("single_cnt", q.size(), 32'd0);
        put(W_SOF, 2'b01); put(W_EOF, 2'b01); idle(4);
        chk("empty_cnt", q.size(), 32'd0);
        chk("empty_fcnt", {16'd0, fcnt}, STATS ? 32'd2 : 32'd0);

        // Abort by in-frame IDLE.
        put(W_SOF, 2'b01); put(16'h0001, 2'b00); idle(4);
        pop("abort", {3'b111, 16'h0001});
        chk("abort_ecnt", {16'd0, ecnt}, STATS ? 32'd1 : 32'd0);
        chk("abort_fcnt", {16'd0, fcnt}, STATS ? 32'd2 : 32'd0);

        // Loss after 8 errored words.
        ce = 2'b01; idle(8); ce = 2'b00;
        idle(1);
        chk("loss_early", {31'd0, link_up}, 32'd1);
        idle(1);
        chk("loss_down", {31'd0, link_up}, 32'd0);
        chk("loss_ecnt", {16'd0, ecnt}, STATS ? 32'd9 : 32'd0);
        idle(6);
        chk("relock", {31'd0, link_up}, 32'd1);

        // 7 errors then a clean IDLE keeps lock.
        ce = 2'b01; idle(7); ce = 2'b00;
        idle(5);
        chk("seven_err", {31'd0, link_up}, 32'd1);
        chk("seven_ecnt", {16'd0, ecnt}, STATS ? 32'd16 : 32'd0);
        q.delete();

        // GT reset mid-frame aborts the held word, then relock on 4 commas.
        put(W_SOF, 2'b01); put(16'h4444, 2'b00); put(16'h5555, 2'b00);
        put(16'h6666, 2'b00); put(16'h7777, 2'b00);
        rdone = 1'b0;
        put(16'h8888, 2'b00);
        chk("gtrst_down", {31'd0, link_up}, 32'd0);
        idle(1);
        rdone = 1'b1;
        idle(4);
        chk("gtrst_hunt", {31'd0, link_up}, 32'd0);
        idle(1);
        chk("gtrst_relock", {31'd0, link_up}, 32'd1);
        pop("gtrst_w0", {3'b100, 16'h4444});
        pop("gtrst_abort", {3'b011, 16'h5555});
        chk("gtrst_cnt", q.size(), 32'd0);
        chk("gtrst_ecnt", {16'd0, ecnt}, STATS ? 32'd17 : 32'd0);

        // Offset 1: comma in byte 1.
        rst_n = 1'b0;
        step();
        chk("rst2_valid", {31'd0, bus.m_valid_o}, 32'd0);
        chk("rst2_link", {31'd0, link_up}, 32'd0);
        rst_n = 1'b1;
        shift = 1'b1; pend_hi = 8'h50; pend_k = 1'b0;
        q.delete();
        idle(6);
        chk("lock1_early", {31'd0, link_up}, 32'd0);
        idle(1);
        chk("lock1_up", {31'd0, link_up}, 32'd1);
        chk("lock1_align", {31'd0, align}, 32'd1);
        put(W_SOF, 2'b01); put(16'h1234, 2'b00); put(16'h5678, 2'b00); put(W_EOF, 2'b01);
        idle(4);
        pop("off1_w0", {3'b100, 16'h1234});
        pop("off1_w1", {3'b010, 16'h5678});
        chk("off1_cnt", q.size(), 32'd0);
        chk("off1_fcnt", {16'd0, fcnt}, STATS ? 32'd1 : 32'd0);
        chk("off1_ecnt", {16'd0, ecnt}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
